// File: rtl/seq_comparator.sv
// Sequential magnitude comparator: walks CHUNK-bit slices from the MSB end and
// stops at the first differing slice, reporting the result and the slice count.
module seq_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  localparam int NCHUNK = (CHUNK < 1) ? 1 : WIDTH / CHUNK,
  localparam int CW     = $clog2(NCHUNK) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic [CW-1:0]    chunks
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("seq_comparator: CHUNK must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CMP, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;

  // Flipping both sign bits maps two's-complement order onto unsigned order,
  // so the slice walk itself never needs to know the mode.
  always_comb begin
    a_cap            = A;
    b_cap            = B;
    a_cap[WIDTH-1]   = A[WIDTH-1] ^ signed_mode;
    b_cap[WIDTH-1]   = B[WIDTH-1] ^ signed_mode;
  end

  always_comb begin
    a_slice = a_q[idx*CHUNK +: CHUNK];
    b_slice = b_q[idx*CHUNK +: CHUNK];
  end

  assign in_ready = (state == IDLE) && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      chunks    <= '0;
      out_valid <= 1'b0;
      A_gt_B    <= 1'b0;
      A_lt_B    <= 1'b0;
      A_eq_B    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q    <= a_cap;
            b_q    <= b_cap;
            idx    <= IW'(NCHUNK - 1);
            chunks <= '0;
            state  <= CMP;
          end
        end
        CMP: begin
          chunks <= chunks + 1'b1;
          if (a_slice != b_slice) begin
            A_gt_B    <= (a_slice > b_slice);
            A_lt_B    <= (a_slice < b_slice);
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (idx == '0) begin
            A_eq_B    <= 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            A_gt_B    <= 1'b0;
            A_lt_B    <= 1'b0;
            A_eq_B    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning the operand width in bits.
REQ-002 SHALL provide parameter CHUNK, default 4, meaning the bits compared per cycle; WIDTH % CHUNK != 0 or CHUNK < 1 SHALL be an elaboration error.
REQ-003 SHALL define NCHUNK = WIDTH/CHUNK and CW = clog2(NCHUNK)+1 as derived widths.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 A  input  WIDTH  operand A, sampled at accept.
REQ-007 B  input  WIDTH  operand B, sampled at accept.
REQ-008 signed_mode  input  1  1 means two's-complement compare, 0 means unsigned; sampled at accept.
REQ-009 in_valid  input  1  request valid.
REQ-010 in_ready  output  1  block can accept a request.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 A_gt_B  output  1  A greater than B.
REQ-014 A_lt_B  output  1  A less than B.
REQ-015 A_eq_B  output  1  A equal to B.
REQ-016 chunks  output  CW  number of chunks examined to reach the result (1..NCHUNK).

Function
REQ-017 SHALL implement FSM states IDLE, CMP and HOLD.
REQ-018 SHALL drive in_ready=1 only in IDLE with rst_n high, and 0 otherwise.
REQ-019 Accept occurs when in_valid && in_ready on a clock edge: latch A, B and signed_mode, set chunk index to NCHUNK-1 (MSB chunk), clear chunks, and go IDLE->CMP.
REQ-020 In signed mode, SHALL invert the MSB of both latched operands at capture, then compare unsigned; in unsigned mode, SHALL leave operands unmodified.
REQ-021 In CMP, each cycle SHALL compare one CHUNK-bit slice at the current index and increment chunks.
REQ-022 If the slices differ, SHALL set exactly one of A_gt_B/A_lt_B per the slice compare and go CMP->HOLD (early termination).
REQ-023 If the slices are equal and the index is 0, SHALL set A_eq_B and go CMP->HOLD.
REQ-024 If the slices are equal and the index is greater than 0, SHALL decrement the index and stay in CMP.
REQ-025 Latency: out_valid SHALL rise m cycles after the accept edge, where m = chunks (m = NCHUNK worst case, 1 best case).
REQ-026 In HOLD, SHALL assert out_valid=1 and hold the flags and chunks stable until out_valid && out_ready, then go to IDLE.
REQ-027 SHALL allow at most one request in flight; in_valid outside IDLE is ignored, with no buffering.
REQ-028 out_ready and in_valid high together in HOLD: the result retires and the new request is accepted on the following cycle (one-cycle bubble).
REQ-029 out_ready asserted while not in HOLD SHALL have no effect.
REQ-030 Exactly one of A_gt_B/A_lt_B/A_eq_B SHALL be 1 whenever out_valid=1; all three SHALL be 0 whenever out_valid=0.
REQ-031 With NCHUNK=1, SHALL resolve in a single CMP cycle.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE, out_valid=0, A_gt_B=0, A_lt_B=0, A_eq_B=0, chunks=0 and in_ready=0, regardless of state.
REQ-033 Reset mid-CMP or mid-HOLD SHALL discard the operation, with no result emitted afterwards.
REQ-034 After rst_n rises, in_ready SHALL be 1 and the next accept SHALL behave as from power-up.

Verification
REQ-035 Bench SHALL cover (WIDTH=16, CHUNK=4): A=0x1234, B=0x1234, unsigned -> A_eq_B=1, chunks=4, out_valid 4 cycles after accept.
REQ-036 Bench SHALL cover: A=0x9000, B=0x1FFF, unsigned -> A_gt_B=1, chunks=1, out_valid 1 cycle after accept; the same operands with signed_mode=1 -> A_lt_B=1, chunks=1.
REQ-037 Bench SHALL cover: A=0x0123, B=0x0124, unsigned -> A_lt_B=1, chunks=4; A=0xFFFF, B=0xFFFE, signed -> A_gt_B=1 (-1 > -2).
REQ-038 Bench SHALL cover: result in HOLD with out_ready=0 for 5 cycles while in_valid=1 with new operands -> flags and chunks stable, in_ready=0, new request not accepted; on out_ready=1, the request is accepted the cycle after retire.
REQ-039 Bench SHALL cover: rst_n pulsed low during CMP of A=0x1234, B=0x1235 -> all outputs 0 within the reset, no stale out_valid afterwards; a subsequent A=5, B=3 yields A_gt_B=1, chunks=4.
REQ-040 Bench SHALL cover: parameter sweep WIDTH/CHUNK in {8/8, 8/1, 32/4} with random operands and both modes -> flags match a reference compare and chunks equals the index of the first differing chunk + 1 (NCHUNK if equal).
